// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_a, b_zero, sa, sb, ge;
  logic [WIDTH-1:0] a_raw, a_mag, b_mag, in_a, in_b, r, q, fix_hi, fix_lo, rem_n;
  logic [WIDTH:0] msum, sh;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod_fix;
  assign busy = state != IDLE;
  always_comb begin
    sa = !op[0] && operandA[WIDTH-1];
    sb = !op[0] && operandB[WIDTH-1];
    in_a = sa ? -operandA : operandA;
    in_b = sb ? -operandB : operandB;
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a_mag : {WIDTH{1'b0}}};
    acc_mul = {msum, acc[WIDTH-1:1]};
    sh = acc[2*WIDTH-1:WIDTH-1];
    ge = sh >= {1'b0, b_mag};
    rem_n = ge ? sh[WIDTH-1:0] - b_mag : sh[WIDTH-1:0];
    acc_div = {rem_n, acc[WIDTH-2:0], ge};
    prod_fix = neg_q ? -acc : acc;
    q = acc[WIDTH-1:0];
    r = acc[2*WIDTH-1:WIDTH];
    fix_hi = !is_div ? prod_fix[2*WIDTH-1:WIDTH] : b_zero ? a_raw : neg_a ? -r : r;
    fix_lo = !is_div ? prod_fix[WIDTH-1:0] : b_zero ? {WIDTH{1'b1}} : neg_q ? -q : q;
    state_n = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (cnt == LAST ? FIXUP : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_a <= 1'b0;
      b_zero <= 1'b0;
      a_raw <= '0;
      a_mag <= '0;
      b_mag <= '0;
      acc <= '0;
    end else begin
      done <= state == FIXUP;
      if (state == IDLE && start) begin
        is_div <= op[1];
        neg_q <= sa ^ sb;
        neg_a <= sa;
        b_zero <= operandB == '0;
        a_raw <= operandA;
        a_mag <= in_a;
        b_mag <= in_b;
        acc <= {{WIDTH{1'b0}}, op[1] ? in_a : in_b};
        cnt <= '0;
      end else if (state == IDLE) begin
        if (mthi) hi <= operandA;
        if (mtlo) lo <= operandA;
      end else if (state == CALC) begin
        acc <= is_div ? acc_div : acc_mul;
        cnt <= cnt + CW'(1);
      end else begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
endmodule
